// File: rtl/psram_req_bridge.sv
// Request-side front end for the asynchronous PSRAM timing controller.
// Queues system read/write requests and issues them one at a time as a
// stb/ack handshake, holding address/data/direction stable until the ack.
module psram_req_bridge #(
  parameter int unsigned DATAW = 16,
  parameter int unsigned ADRW  = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [ADRW-1:0]  req_adr_i,
  input  logic [DATAW-1:0] req_dat_i,
  output logic             rsp_valid_o,
  output logic [DATAW-1:0] rsp_dat_o,
  output logic             ctl_stb_o,
  output logic             ctl_we_o,
  input  logic             ctl_ack_i,
  output logic [ADRW-1:0]  mem_adr_o,
  output logic [DATAW-1:0] mem_dat_o,
  output logic             mem_dat_oe_o,
  input  logic [DATAW-1:0] mem_dat_i,
  output logic             busy_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  logic [ADRW-1:0]  fifo_adr_q [DEPTH];
  logic [ADRW-1:0]  fifo_adr_d [DEPTH];
  logic [DATAW-1:0] fifo_dat_q [DEPTH];
  logic [DATAW-1:0] fifo_dat_d [DEPTH];
  logic [DEPTH-1:0] fifo_we_q, fifo_we_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rdy_en_q, rdy_en_d;
  logic [1:0]       state_q, state_d;
  logic [ADRW-1:0]  adr_q, adr_d;
  logic [DATAW-1:0] dat_q, dat_d;
  logic             we_q, we_d;
  logic             oe_q, oe_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DATAW-1:0] rsp_dat_q, rsp_dat_d;
  logic             push, pop;

  // Handshake qualifiers; pops only happen when the FSM can take a new request.
  always_comb begin
    push = req_valid_i & req_ready_o;
    pop  = (state_q == StIdle) & (cnt_q != '0);
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    fifo_adr_d = fifo_adr_q;
    fifo_dat_d = fifo_dat_q;
    fifo_we_d  = fifo_we_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    // Ready is held low during reset and goes high one cycle after release.
    rdy_en_d   = 1'b1;
    if (push) begin
      fifo_adr_d[wr_ptr_q] = req_adr_i;
      fifo_dat_d[wr_ptr_q] = req_dat_i;
      fifo_we_d[wr_ptr_q]  = req_we_i;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Transaction FSM: IDLE loads the head entry, ISSUE strobes, WAIT holds until ack.
  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    oe_d        = oe_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          adr_d   = fifo_adr_q[rd_ptr_q];
          dat_d   = fifo_dat_q[rd_ptr_q];
          we_d    = fifo_we_q[rd_ptr_q];
          oe_d    = fifo_we_q[rd_ptr_q];
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (ctl_ack_i) begin
          if (!we_q) begin
            rsp_dat_d   = mem_dat_i;
            rsp_valid_d = 1'b1;
          end
          oe_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset drops queued and in-flight requests.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_adr_q[i] <= '0;
        fifo_dat_q[i] <= '0;
      end
      fifo_we_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rdy_en_q    <= 1'b0;
      state_q     <= StIdle;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      fifo_adr_q  <= fifo_adr_d;
      fifo_dat_q  <= fifo_dat_d;
      fifo_we_q   <= fifo_we_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rdy_en_q    <= rdy_en_d;
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  // Output decode.
  always_comb begin
    req_ready_o  = rdy_en_q & (cnt_q != FullCnt);
    rsp_valid_o  = rsp_valid_q;
    rsp_dat_o    = rsp_dat_q;
    ctl_stb_o    = (state_q == StIssue);
    ctl_we_o     = we_q;
    mem_adr_o    = adr_q;
    mem_dat_o    = dat_q;
    mem_dat_oe_o = oe_q;
    busy_o       = (cnt_q != '0) | (state_q != StIdle);
  end

endmodule

// File: tb/tb_psram_req_bridge.sv
// Directed bench for psram_req_bridge: the bench plays the timing controller,
// driving ctl_ack_i / mem_dat_i, and checks the handshake and response ports.
module tb_psram_req_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [17:0] req_adr_i = '0;
  logic [15:0] req_dat_i = '0;
  logic        rsp_valid_o;
  logic [15:0] rsp_dat_o;
  logic        ctl_stb_o;
  logic        ctl_we_o;
  logic        ctl_ack_i = 1'b0;
  logic [17:0] mem_adr_o;
  logic [15:0] mem_dat_o;
  logic        mem_dat_oe_o;
  logic [15:0] mem_dat_i = '0;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] model_word;

  psram_req_bridge #(.DATAW(16), .ADRW(18), .DEPTH(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_adr_i    (req_adr_i),
    .req_dat_i    (req_dat_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_dat_o    (rsp_dat_o),
    .ctl_stb_o    (ctl_stb_o),
    .ctl_we_o     (ctl_we_o),
    .ctl_ack_i    (ctl_ack_i),
    .mem_adr_o    (mem_adr_o),
    .mem_dat_o    (mem_dat_o),
    .mem_dat_oe_o (mem_dat_oe_o),
    .mem_dat_i    (mem_dat_i),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rst_outs(input string tag);
    check({tag, "_ready"}, 32'(req_ready_o), 0);
    check({tag, "_rspv"}, 32'(rsp_valid_o), 0);
    check({tag, "_rspd"}, 32'(rsp_dat_o), 0);
    check({tag, "_stb"}, 32'(ctl_stb_o), 0);
    check({tag, "_we"}, 32'(ctl_we_o), 0);
    check({tag, "_adr"}, 32'(mem_adr_o), 0);
    check({tag, "_dat"}, 32'(mem_dat_o), 0);
    check({tag, "_oe"}, 32'(mem_dat_oe_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic push(input logic we, input logic [17:0] adr, input logic [15:0] dat);
    int n = 0;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_adr_i   = adr;
    req_dat_i   = dat;
    while (!req_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("push_ready", 32'(req_ready_o), 1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  // Waits (bounded) for the strobe, looking at the current cycle first.
  task automatic wait_stb(input logic we, input logic [17:0] adr, input logic [15:0] dat);
    int n = 0;
    while (!ctl_stb_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("stb_seen", 32'(ctl_stb_o), 1);
    check("stb_adr", 32'(mem_adr_o), 32'(adr));
    check("stb_we", 32'(ctl_we_o), 32'(we));
    check("stb_oe", 32'(mem_dat_oe_o), 32'(we));
    if (we) check("stb_dat", 32'(mem_dat_o), 32'(dat));
    check("stb_rsp_low", 32'(rsp_valid_o), 0);
  endtask

  // Pulses ack for one cycle in WAIT and checks the response the cycle after.
  task automatic ack_now(input logic we, input logic [15:0] rd);
    ctl_ack_i = 1'b1;
    mem_dat_i = rd;
    @(negedge clk_i);
    ctl_ack_i = 1'b0;
    check("ack_rspv", 32'(rsp_valid_o), 32'(!we));
    if (!we) check("ack_rspd", 32'(rsp_dat_o), 32'(rd));
    check("ack_oe", 32'(mem_dat_oe_o), 0);
  endtask

  task automatic serve(input logic we, input logic [17:0] adr, input logic [15:0] dat,
                       input logic [15:0] rd, input int delay);
    wait_stb(we, adr, dat);
    for (int i = 1; i <= delay; i++) begin
      @(negedge clk_i);
      check("wait_stb_low", 32'(ctl_stb_o), 0);
      check("wait_adr", 32'(mem_adr_o), 32'(adr));
      check("wait_we", 32'(ctl_we_o), 32'(we));
      check("wait_oe", 32'(mem_dat_oe_o), 32'(we));
      if (we) check("wait_dat", 32'(mem_dat_o), 32'(dat));
      check("wait_busy", 32'(busy_o), 1);
    end
    ack_now(we, rd);
  endtask

  initial begin
    // Reset values
    @(negedge clk_i);
    @(negedge clk_i);
    check_rst_outs("rst");
    rst_i = 1'b0;
    #1 check("ready_at_release", 32'(req_ready_o), 0);
    @(negedge clk_i);
    check("ready_after_release", 32'(req_ready_o), 1);

    // 1: single write, ack 5 cycles after stb, no response
    push(1'b1, 18'h00012, 16'hBEEF);
    check("t1_busy", 32'(busy_o), 1);
    serve(1'b1, 18'h00012, 16'hBEEF, 16'h0000, 5);
    check("t1_idle_busy", 32'(busy_o), 0);

    // 2: read at top address; response held afterwards
    push(1'b0, 18'h3FFFF, 16'h0000);
    serve(1'b0, 18'h3FFFF, 16'h0000, 16'h1234, 3);
    for (int i = 0; i < 3; i++) @(negedge clk_i);
    check("t2_rspv_pulse", 32'(rsp_valid_o), 0);
    check("t2_rspd_held", 32'(rsp_dat_o), 32'h1234);

    // 3: ack stalled; one request in flight plus four queued fills the bridge
    push(1'b0, 18'h00101, 16'h0000);
    push(1'b0, 18'h00102, 16'h0000);
    push(1'b1, 18'h00103, 16'hC0DE);
    push(1'b0, 18'h00104, 16'h0000);
    push(1'b0, 18'h00105, 16'h0000);
    check("t3_full_ready", 32'(req_ready_o), 0);
    check("t3_busy", 32'(busy_o), 1);
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_adr_i   = 18'h00106;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("t3_hold_ready", 32'(req_ready_o), 0);
      check("t3_hold_stb", 32'(ctl_stb_o), 0);
      check("t3_hold_adr", 32'(mem_adr_o), 32'h00101);
    end

    // 4: ack frees a slot while the sixth request is still offered
    ack_now(1'b0, 16'h0101);
    check("t4_ready_pre_pop", 32'(req_ready_o), 0);
    @(negedge clk_i);
    check("t4_stb_b", 32'(ctl_stb_o), 1);
    check("t4_adr_b", 32'(mem_adr_o), 32'h00102);
    check("t4_ready_after_pop", 32'(req_ready_o), 1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check("t4_refull_ready", 32'(req_ready_o), 0);
    check("t4_wait_adr_b", 32'(mem_adr_o), 32'h00102);
    ack_now(1'b0, 16'h0102);
    serve(1'b1, 18'h00103, 16'hC0DE, 16'h0000, 1);
    serve(1'b0, 18'h00104, 16'h0000, 16'h0104, 1);
    serve(1'b0, 18'h00105, 16'h0000, 16'h0105, 2);
    serve(1'b0, 18'h00106, 16'h0000, 16'h0106, 1);
    check("t4_drained", 32'(busy_o), 0);

    // 5: asynchronous reset during WAIT, late ack afterwards
    push(1'b0, 18'h00155, 16'h0000);
    wait_stb(1'b0, 18'h00155, 16'h0000);
    @(negedge clk_i);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1 check_rst_outs("t5_async");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    ctl_ack_i = 1'b1;
    mem_dat_i = 16'hDEAD;
    @(negedge clk_i);
    ctl_ack_i = 1'b0;
    check("t5_late_rspv", 32'(rsp_valid_o), 0);
    check("t5_late_rspd", 32'(rsp_dat_o), 0);
    check("t5_busy", 32'(busy_o), 0);
    check("t5_ready", 32'(req_ready_o), 1);

    // 6: write then read of the same word; the bench's memory model answers
    push(1'b1, 18'h00010, 16'hA5A5);
    push(1'b0, 18'h00010, 16'h0000);
    wait_stb(1'b1, 18'h00010, 16'hA5A5);
    model_word = mem_dat_o;
    @(negedge clk_i);
    check("t6_busy_w", 32'(busy_o), 1);
    ack_now(1'b1, 16'h0000);
    check("t6_busy_between", 32'(busy_o), 1);
    serve(1'b0, 18'h00010, 16'h0000, model_word, 2);
    check("t6_rspd", 32'(rsp_dat_o), 32'hA5A5);
    check("t6_busy_end", 32'(busy_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
